systolic_feeder: RTL

//  Serially loads an N-lane x K-word operand buffer for both X (rows) and Y (cols), S_W bits/beat.
//  On start, replays the buffer into the systolic array edge with a 1-cycle-per-lane diagonal skew.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/feeder_lane.sv | 45 ++++
 rtl/systolic_feeder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic operand feeder.
package tpu_pkg;

  // Feeder control states: empty, partially loaded, loaded, replaying.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2,
    FEED = 2'd3
  } feeder_state_t;

  // Bits needed to hold the values 0..max_count, never less than one bit.
  function automatic int cnt_w(input int max_count);
    int w;
    w = $clog2(max_count + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One lane of operand storage: K words of D_W bits, a single write port and
// a registered read port that returns zero whenever no read is requested.
module feeder_lane #(
  parameter int D_W = 8,
  parameter int K   = 4,
  parameter int A_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [A_W-1:0] waddr_i,
  input  logic [D_W-1:0] wdata_i,
  input  logic           re_i,
  input  logic [A_W-1:0] raddr_i,
  output logic [D_W-1:0] rdata_o
);

  logic [D_W-1:0] mem_q [K];
  logic [D_W-1:0] rdata_q;

  // Word storage, written once per completed serial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 32'sd0; i < K; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; idle lanes present zero so the array edge sees clean data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/systolic_feeder.sv
// Serially loads N lanes x K words of X and Y operands, then replays them into
// the systolic array edge with lane i delayed by i cycles.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 4,
  parameter int K   = 4,
  parameter int S_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [S_W-1:0]   load_x,
  input  logic [S_W-1:0]   load_y,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [N-1:0]     out_valid,
  output logic [N*D_W-1:0] out_x,
  output logic [N*D_W-1:0] out_y
);

  localparam int BEATS  = D_W / S_W;
  localparam int ASM_W  = (BEATS > 1) ? (D_W - S_W) : 1;
  localparam int BIT_W  = cnt_w(BEATS - 1);
  localparam int WORD_W = cnt_w(K - 1);
  localparam int LANE_W = cnt_w(N - 1);
  // One step beyond the last skewed step drains the pipeline and raises done.
  localparam int STEP_W = cnt_w(K + N - 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BEATS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(K - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(K + N - 1);

  feeder_state_t     state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ASM_W-1:0]  x_asm_q, x_asm_d, y_asm_q, y_asm_d;
  logic              load_ready_q, load_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [N-1:0]      out_valid_q;

  logic              accept_s;
  logic              word_wr_s;
  logic [D_W-1:0]    x_word_s, y_word_s;
  logic [ASM_W-1:0]  x_asm_next_s, y_asm_next_s;
  logic [N-1:0]      we_s;
  logic [N-1:0]      rd_en_s;
  logic [WORD_W-1:0] rd_addr_s [N];

  // The newest slice lands on top so the first slice ends up in the LSBs.
  if (BEATS == 1) begin : g_whole
    assign x_word_s     = load_x;
    assign y_word_s     = load_y;
    assign x_asm_next_s = '0;
    assign y_asm_next_s = '0;
  end else begin : g_shift
    assign x_word_s     = {load_x, x_asm_q};
    assign y_word_s     = {load_y, y_asm_q};
    assign x_asm_next_s = x_word_s[D_W-1:S_W];
    assign y_asm_next_s = y_word_s[D_W-1:S_W];
  end

  assign accept_s  = load_valid && load_ready_q;
  assign word_wr_s = accept_s && (bit_q == LAST_BIT) && !clear;

  // Next-state logic: serial fill counters, start/clear handling, feed stepping.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    lane_d  = lane_q;
    step_d  = step_q;
    x_asm_d = x_asm_q;
    y_asm_d = y_asm_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      bit_d   = '0;
      word_d  = '0;
      lane_d  = '0;
      step_d  = '0;
      x_asm_d = '0;
      y_asm_d = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          error_d = start;
          if (accept_s) begin
            x_asm_d = x_asm_next_s;
            y_asm_d = y_asm_next_s;
            state_d = LOAD;
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
              if (word_q == LAST_WORD) begin
                word_d = '0;
                if (lane_q == LAST_LANE) begin
                  lane_d  = '0;
                  state_d = FULL;
                end else begin
                  lane_d = lane_q + LANE_W'(1'b1);
                end
              end else begin
                word_d = word_q + WORD_W'(1'b1);
              end
            end else begin
              bit_d = bit_q + BIT_W'(1'b1);
            end
          end else begin
            state_d = state_q;
          end
        end
        FULL: begin
          if (start) begin
            state_d = FEED;
            step_d  = '0;
          end else begin
            state_d = FULL;
          end
        end
        FEED: begin
          if (step_q == LAST_STEP) begin
            state_d = FULL;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1'b1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    load_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d       = (state_d == FEED);
  end

  // Skewed read schedule: at step t lane i reads word t-i while it is in range.
  always_comb begin
    rd_en_s = '0;
    we_s    = '0;
    for (int i = 32'sd0; i < N; i++) begin
      rd_addr_s[i] = '0;
      we_s[i]      = word_wr_s && (lane_q == LANE_W'(i));
    end
    if ((state_q == FEED) && !clear) begin
      for (int i = 32'sd0; i < N; i++) begin
        if ((int'(step_q) >= i) && (int'(step_q) < i + K)) begin
          rd_en_s[i]   = 1'b1;
          rd_addr_s[i] = WORD_W'(int'(step_q) - i);
        end else begin
          rd_en_s[i]   = 1'b0;
          rd_addr_s[i] = '0;
        end
      end
    end else begin
      rd_en_s = '0;
    end
  end

  // Control and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      word_q       <= '0;
      lane_q       <= '0;
      step_q       <= '0;
      x_asm_q      <= '0;
      y_asm_q      <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      out_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      step_q       <= step_d;
      x_asm_q      <= x_asm_d;
      y_asm_q      <= y_asm_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      out_valid_q  <= rd_en_s;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    feeder_lane #(.D_W(D_W), .K(K), .A_W(WORD_W)) u_x (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we_s[g]),
      .waddr_i (word_q),
      .wdata_i (x_word_s),
      .re_i    (rd_en_s[g]),
      .raddr_i (rd_addr_s[g]),
      .rdata_o (out_x[g*D_W +: D_W])
    );
    feeder_lane #(.D_W(D_W), .K(K), .A_W(WORD_W)) u_y (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we_s[g]),
      .waddr_i (word_q),
      .wdata_i (y_word_s),
      .re_i    (rd_en_s[g]),
      .raddr_i (rd_addr_s[g]),
      .rdata_o (out_y[g*D_W +: D_W])
    );
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign out_valid  = out_valid_q;

endmodule
